// File: rtl/loop_stack_if.sv
// Decoder-side bundle for loop_stack: request/data in, top/level/status out.
// err[1:0] exists only when LOOP_STACK_ERR_EN is defined.
interface loop_stack_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
);
    logic             flush;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [DEPTH:0]   level;
    logic             empty;
    logic             full;
`ifdef LOOP_STACK_ERR_EN
    logic [1:0]       err;
`endif

    modport master (
        output flush, push, pop, din,
`ifdef LOOP_STACK_ERR_EN
        input  err,
`endif
        input  top, level, empty, full
    );

    modport slave (
        input  flush, push, pop, din,
`ifdef LOOP_STACK_ERR_EN
        output err,
`endif
        output top, level, empty, full
    );
endinterface

// File: rtl/loop_stack.sv
// Self-managing LIFO for loop return addresses: push, pop, replace-top, flush.
// Optional sticky overflow/underflow flags when LOOP_STACK_ERR_EN is defined.
module loop_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           resetq,
    loop_stack_if.slave    bus
);
    localparam int unsigned CAP = 1 << DEPTH;
    localparam logic [DEPTH:0] SP_FULL = {1'b1, {DEPTH{1'b0}}};

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_OVF,
        OP_UDF
    } op_e;

    logic [WIDTH-1:0] store_q [CAP];
    logic [DEPTH:0]   sp_q, sp_d;

    op_e              op;
    logic             wr_en;
    logic [DEPTH-1:0] wr_idx;
    logic [DEPTH-1:0] sp_idx;
    logic [DEPTH-1:0] top_idx;
    logic             empty_w;
    logic             full_w;

    assign sp_idx  = sp_q[DEPTH-1:0];
    // When full, sp_idx is 0 and this wraps to the last slot, which is the real top.
    assign top_idx = sp_idx - DEPTH'(1);
    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == SP_FULL);

    assign bus.level = sp_q;
    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.top   = empty_w ? '0 : store_q[top_idx];

    always_comb begin
        op = OP_HOLD;
        if (bus.flush) begin
            op = OP_CLEAR;
        end else if (bus.push && bus.pop) begin
            op = empty_w ? OP_PUSH : OP_REPLACE;
        end else if (bus.push) begin
            op = full_w ? OP_OVF : OP_PUSH;
        end else if (bus.pop) begin
            op = empty_w ? OP_UDF : OP_POP;
        end
    end

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = sp_idx;
        case (op)
            OP_CLEAR: sp_d = '0;
            OP_PUSH: begin
                wr_en  = 1'b1;
                wr_idx = sp_idx;
                sp_d   = sp_q + (DEPTH+1)'(1);
            end
            OP_POP: sp_d = sp_q - (DEPTH+1)'(1);
            OP_REPLACE: begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            default: ;
        endcase
        if (resetq) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetq) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_q[wr_idx] <= din_hold();
        end
    end

    function automatic logic [WIDTH-1:0] din_hold();
        return bus.din;
    endfunction

`ifdef LOOP_STACK_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (op == OP_CLEAR) begin
            err_d = '0;
        end else begin
            if (op == OP_OVF) err_d[0] = 1'b1;
            if (op == OP_UDF) err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetq) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_loop_stack.sv
// Directed bench for loop_stack (DEPTH=2, WIDTH=16): vector table plus
// held-push saturation and no-bypass sequences.
module tb_loop_stack;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic resetq;

    loop_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    loop_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        push;
        logic        pop;
        logic [15:0] din;
        logic [2:0]  level;
        logic [15:0] top;
        logic        empty;
        logic        full;
        logic [1:0]  err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic pu, input logic po, input logic [15:0] d);
        resetq   = r;
        bus.flush = f;
        bus.push  = pu;
        bus.pop   = po;
        bus.din   = d;
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic [2:0] lv,
                                 input logic [15:0] tp, input logic em, input logic fu,
                                 input logic [1:0] er);
        chk({tag, ".level"}, idx, 32'(bus.level), 32'(lv));
        chk({tag, ".top"},   idx, 32'(bus.top),   32'(tp));
        chk({tag, ".empty"}, idx, 32'(bus.empty), 32'(em));
        chk({tag, ".full"},  idx, 32'(bus.full),  32'(fu));
`ifdef LOOP_STACK_ERR_EN
        chk({tag, ".err"},   idx, 32'(bus.err),   32'(er));
`else
        if (er === 2'bxx) $display("unreachable");
`endif
    endtask

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic f, input logic pu, input logic po,
                                input logic [15:0] d, input logic [2:0] lv, input logic [15:0] tp,
                                input logic em, input logic fu, input logic [1:0] er);
        vec_t v;
        v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.din = d;
        v.level = lv; v.top = tp; v.empty = em; v.full = fu; v.err = er;
        return v;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        //            rst  fl   pu   po   din       lvl   top       em   fu   err
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,3'd0,16'h0000,1'b1,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0010,3'd1,16'h0010,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0020,3'd2,16'h0020,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0030,3'd3,16'h0030,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0040,3'd4,16'h0040,1'b0,1'b1,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0050,3'd4,16'h0040,1'b0,1'b1,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'h0099,3'd4,16'h0099,1'b0,1'b1,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd3,16'h0030,1'b0,1'b0,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd2,16'h0020,1'b0,1'b0,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd1,16'h0010,1'b0,1'b0,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd0,16'h0000,1'b1,1'b0,2'b01));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd0,16'h0000,1'b1,1'b0,2'b11));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'h00AA,3'd1,16'h00AA,1'b0,1'b0,2'b11));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0011,3'd2,16'h0011,1'b0,1'b0,2'b11));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0022,3'd3,16'h0022,1'b0,1'b0,2'b11));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,16'h0055,3'd0,16'h0000,1'b1,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0033,3'd1,16'h0033,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0044,3'd2,16'h0044,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0066,3'd3,16'h0066,1'b0,1'b0,2'b00));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,16'h0077,3'd0,16'h0000,1'b1,1'b0,2'b00));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd0,16'h0000,1'b1,1'b0,2'b10));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h1234,3'd0,16'h0000,1'b1,1'b0,2'b10));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0001,3'd1,16'h0001,1'b0,1'b0,2'b10));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0000,3'd0,16'h0000,1'b1,1'b0,2'b10));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].din);
            @(posedge clk);
            @(negedge clk);
            check_outputs("vec", i, vecs[i].level, vecs[i].top, vecs[i].empty,
                          vecs[i].full, vecs[i].err);
        end

        // Held push with changing data saturates at four entries; the fifth push overflows.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
            @(posedge clk);
            @(negedge clk);
            check_outputs("held", i,
                          (i < 4) ? 3'(i + 1) : 3'd4,
                          (i < 4) ? 16'h0100 + 16'(i) : 16'h0103,
                          1'b0, (i >= 3),
                          (i >= 4) ? 2'b01 : 2'b00);
        end

        // Replace while full: din must not reach top until after the edge.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        #1;
        chk("nobypass.top", 0, 32'(bus.top), 32'h0103);
        @(posedge clk);
        @(negedge clk);
        check_outputs("replace", 0, 3'd4, 16'hBEEF, 1'b0, 1'b1, 2'b01);

        // Pops after replace expose the untouched lower entries.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check_outputs("popr", 0, 3'd3, 16'h0102, 1'b0, 1'b0, 2'b01);
        @(posedge clk);
        @(negedge clk);
        check_outputs("popr", 1, 3'd2, 16'h0101, 1'b0, 1'b0, 2'b01);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check_outputs("idle", 0, 3'd2, 16'h0101, 1'b0, 1'b0, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
